parking_gate_arbiter: RTL
=========================

Name: parking_gate_arbiter

Overview:
- Controller that shares a single barrier gate between the entrance and exit lanes of the parking system.
- Sequences password check, gate-open timing and lockout, and tracks occupancy against capacity.
- Drives the GREEN/RED LEDs and two 7-segment occupancy digits.
- Sits between the lane sensors/keypad and the gate actuator.

Parameters:
- CAPACITY, 8, number of spaces; legal range 1..255.
- PASS_1, 2'b01, expected value on password_1.
- PASS_2, 2'b10, expected value on password_2.
- GATE_OPEN_CYCLES, 16, cycles gate_open is held per passage; must be >= 1.
- PASS_TIMEOUT, 32, cycles allowed in WAIT_PASS/WRONG_PASS without a pass_valid.
- MAX_TRIES, 3, consecutive wrong passwords that trigger lockout.
- LOCK_CYCLES, 64, lockout duration.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous, active-high reset.
- sensor_entrance, input, 1, level: car present at entrance.
- sensor_exit, input, 1, level: car present at exit.
- password_1, input, 2, first password digit.
- password_2, input, 2, second password digit.
- pass_valid, input, 1, single-cycle strobe: password_1/2 valid this cycle.
- gate_open, output, 1, barrier actuator.
- GREEN_LED, output, 1, passage granted.
- RED_LED, output, 1, waiting, wrong password or locked.
- full, output, 1, occupancy == CAPACITY.
- lockout, output, 1, high in LOCKED.
- occupancy, output, 8, cars currently parked.
- HEX_1, output, 7, active-low segments {g..a}: occupancy[7:4] as hex 0-F.
- HEX_2, output, 7, active-low segments {g..a}: occupancy[3:0] as hex 0-F.

Behaviour:
- Reset (async): state IDLE, occupancy 0, tries 0, timer 0. gate_open/GREEN/RED/lockout/full = 0; HEX_1 = HEX_2 = 7'b1000000.
- All outputs are Moore outputs decoded from registers; no input-to-output combinational path.
- IDLE: both LEDs off.
  - sensor_exit=1 -> EXIT_OPEN. Exit has priority when both sensors are high.
  - Else sensor_entrance=1 and !full -> WAIT_PASS; timer cleared.
  - sensor_entrance=1 and full -> stay IDLE with RED_LED=1 while the condition holds.
- WAIT_PASS: RED=1. The timer counts every cycle.
  - pass_valid with match (password_1==PASS_1 && password_2==PASS_2) -> ENTRY_OPEN; tries cleared.
  - pass_valid with mismatch -> tries+1. If the new tries == MAX_TRIES -> LOCKED, else WRONG_PASS. Timer cleared either way.
  - Timer reaches PASS_TIMEOUT-1 without pass_valid -> IDLE; tries preserved.
  - sensor_exit is not served in this state. The level is held and serviced on return to IDLE.
- WRONG_PASS: RED=1. Same transitions as WAIT_PASS; the state exists so verification can observe retries.
- ENTRY_OPEN: gate_open=1, GREEN=1, held exactly GATE_OPEN_CYCLES cycles, then IDLE.
  - occupancy increments on the clock edge that enters ENTRY_OPEN; full updates on the same edge.
- EXIT_OPEN: gate_open=1, GREEN=1, held exactly GATE_OPEN_CYCLES cycles, then IDLE.
  - occupancy decrements on the entry edge and saturates at 0; the gate still opens at 0.
- LOCKED: RED=1, lockout=1, gate closed. All inputs ignored, including sensor_exit.
  - After exactly LOCK_CYCLES cycles -> IDLE; tries cleared.
- pass_valid outside WAIT_PASS/WRONG_PASS is ignored.
- occupancy never exceeds CAPACITY; entry is only granted when !full.
- Reset asserted mid-passage: gate closes immediately and occupancy returns to 0. Occupancy is not retained across reset.

Decomposition:
- Shared package parking_pkg:
  - state enum: IDLE, WAIT_PASS, WRONG_PASS, ENTRY_OPEN, EXIT_OPEN, LOCKED.
  - seven-segment blank/zero constants.
  - occupancy width constant (8).
- Sub-module hex_to_seg7: 4-bit hex to active-low 7-segment, combinational, instantiated twice.
- FSM, timer, tries and occupancy counters stay in parking_gate_arbiter.

Test Plan:
- Correct password entry:
  - Stimulus: reset 100 ns; sensor_entrance=1; pass_valid with 01/10.
  - Response: ENTRY_OPEN next edge; gate_open=1, GREEN=1 for 16 cycles; occupancy 0->1; HEX_2=7'b1111001.
- Three wrong passwords:
  - Stimulus: 11/11 strobed three times.
  - Response: WRONG_PASS after #1 and #2; LOCKED after #3 with lockout=1, RED=1. An exit request during lockout is ignored. IDLE after 64 cycles, tries=0.
- Fill to capacity:
  - Stimulus: 8 successful entries, then sensor_entrance held.
  - Response: full=1; state stays IDLE, RED=1, gate_open=0.
- Simultaneous sensors:
  - Stimulus: both sensors rise in the same cycle with occupancy=5.
  - Response: EXIT_OPEN first, occupancy=4; then WAIT_PASS for the entrance.
- Password timeout and underflow:
  - Stimulus: no pass_valid for 32 cycles in WAIT_PASS.
  - Response: returns to IDLE, RED=0.
  - Stimulus: an exit at occupancy=0.
  - Response: gate opens for 16 cycles, occupancy stays 0.
- Async reset mid-passage:
  - Stimulus: reset asserted in cycle 5 of ENTRY_OPEN.
  - Response: gate_open=0 and occupancy=0 without waiting for a clock edge.

Source files
------------

// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking gate controller: the controller state
// encoding, the occupancy counter width and the seven-segment constants used
// by the occupancy display decoder.
// ---------------------------------------------------------------------------
package parking_pkg;

   // Controller states; the encoding is shared with anything that observes state
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_PASS  = 3'd1,
      WRONG_PASS = 3'd2,
      ENTRY_OPEN = 3'd3,
      EXIT_OPEN  = 3'd4,
      LOCKED     = 3'd5
   } state_t;

   // Width of the occupancy counter and of the occupancy output
   localparam int OCC_W = 8;

   // Active-low segment patterns ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational decoder from one hex nibble to an active-low
// seven-segment pattern ordered {g,f,e,d,c,b,a}.
// Ports:
//   hex_i  - 4-bit value to display (0..F)
//   seg_o  - active-low segment drive, bit 0 = segment a
// ---------------------------------------------------------------------------
module hex_to_seg7
   import parking_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0
   always_comb begin
      seg_o = SEG_BLANK;
      case (hex_i)
         4'h0: seg_o = SEG_ZERO;
         4'h1: seg_o = 7'b1111001;
         4'h2: seg_o = 7'b0100100;
         4'h3: seg_o = 7'b0110000;
         4'h4: seg_o = 7'b0011001;
         4'h5: seg_o = 7'b0010010;
         4'h6: seg_o = 7'b0000010;
         4'h7: seg_o = 7'b1111000;
         4'h8: seg_o = 7'b0000000;
         4'h9: seg_o = 7'b0010000;
         4'hA: seg_o = 7'b0001000;
         4'hB: seg_o = 7'b0000011;
         4'hC: seg_o = 7'b1000110;
         4'hD: seg_o = 7'b0100001;
         4'hE: seg_o = 7'b0000110;
         4'hF: seg_o = 7'b0001110;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/parking_gate_arbiter.sv
// ---------------------------------------------------------------------------
// parking_gate_arbiter
// Shares one barrier gate between the entrance and exit lanes. Sequences the
// password check, gate-open timing and wrong-password lockout, and keeps the
// occupancy count against capacity. All outputs are decoded from registers.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   sensor_entrance/exit  - car-present levels at each lane
//   password_1/2          - keypad digits, qualified by pass_valid
//   pass_valid            - single-cycle strobe for the password digits
//   gate_open             - barrier actuator
//   GREEN_LED / RED_LED   - passage granted / waiting, wrong or locked
//   full, lockout         - occupancy at capacity / controller in lockout
//   occupancy             - cars currently parked
//   HEX_1 / HEX_2         - active-low digits for occupancy[7:4] / [3:0]
// ---------------------------------------------------------------------------
module parking_gate_arbiter
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY         = 8,
   parameter logic [1:0]  PASS_1           = 2'b01,
   parameter logic [1:0]  PASS_2           = 2'b10,
   parameter int unsigned GATE_OPEN_CYCLES = 16,
   parameter int unsigned PASS_TIMEOUT     = 32,
   parameter int unsigned MAX_TRIES        = 3,
   parameter int unsigned LOCK_CYCLES      = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sensor_entrance,
   input  logic             sensor_exit,
   input  logic [1:0]       password_1,
   input  logic [1:0]       password_2,
   input  logic             pass_valid,
   output logic             gate_open,
   output logic             GREEN_LED,
   output logic             RED_LED,
   output logic             full,
   output logic             lockout,
   output logic [OCC_W-1:0] occupancy,
   output logic [6:0]       HEX_1,
   output logic [6:0]       HEX_2
);

   localparam int TIMER_W = 16;

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [7:0]         tries_q, tries_d;
   logic [OCC_W-1:0]   occupancy_q, occupancy_d;
   logic               redFull_q, redFull_d;
   logic [7:0]         triesInc;
   logic               passMatch;
   logic               fullFlag;

   assign triesInc  = tries_q + 8'd1;
   assign passMatch = (password_1 == PASS_1) && (password_2 == PASS_2);
   assign fullFlag  = (occupancy_q == OCC_W'(CAPACITY));

   // Next-state logic. One shared timer serves the password timeout, the gate
   // hold and the lockout; it is cleared on every edge that enters a timed
   // state so each state sees it start from zero. The "full, car waiting"
   // red indication is registered so RED_LED never follows an input
   // combinationally.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      tries_d     = tries_q;
      occupancy_d = occupancy_q;
      redFull_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sensor_exit) begin
               state_d = EXIT_OPEN;
               timer_d = '0;
               if (occupancy_q != '0) begin
                  occupancy_d = occupancy_q - OCC_W'(1);
               end
            end else if (sensor_entrance) begin
               if (!fullFlag) begin
                  state_d = WAIT_PASS;
                  timer_d = '0;
               end else begin
                  redFull_d = 1'b1;
               end
            end
         end
         WAIT_PASS, WRONG_PASS: begin
            if (pass_valid) begin
               timer_d = '0;
               if (passMatch) begin
                  state_d = ENTRY_OPEN;
                  tries_d = '0;
                  if (occupancy_q < OCC_W'(CAPACITY)) begin
                     occupancy_d = occupancy_q + OCC_W'(1);
                  end
               end else begin
                  tries_d = triesInc;
                  state_d = (triesInc == 8'(MAX_TRIES)) ? LOCKED : WRONG_PASS;
               end
            end else if (timer_q == TIMER_W'(PASS_TIMEOUT - 1)) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ENTRY_OPEN, EXIT_OPEN: begin
            if (timer_q == TIMER_W'(GATE_OPEN_CYCLES - 1)) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         LOCKED: begin
            if (timer_q == TIMER_W'(LOCK_CYCLES - 1)) begin
               state_d = IDLE;
               timer_d = '0;
               tries_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // State registers; reset drops the gate and forgets occupancy at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         tries_q     <= '0;
         occupancy_q <= '0;
         redFull_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         tries_q     <= tries_d;
         occupancy_q <= occupancy_d;
         redFull_q   <= redFull_d;
      end
   end

   // Moore output decode from the state and occupancy registers
   assign gate_open = (state_q == ENTRY_OPEN) || (state_q == EXIT_OPEN);
   assign GREEN_LED = gate_open;
   assign RED_LED   = (state_q == WAIT_PASS) || (state_q == WRONG_PASS) ||
                      (state_q == LOCKED) || ((state_q == IDLE) && redFull_q);
   assign lockout   = (state_q == LOCKED);
   assign full      = fullFlag;
   assign occupancy = occupancy_q;

   // Occupancy display, high nibble on HEX_1 and low nibble on HEX_2
   hex_to_seg7 uHexHigh (
      .hex_i (occupancy_q[7:4]),
      .seg_o (HEX_1)
   );

   hex_to_seg7 uHexLow (
      .hex_i (occupancy_q[3:0]),
      .seg_o (HEX_2)
   );

endmodule
